mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: DWELL_W, default 4, width of the per-channel dwell count.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  begin a scan; sampled only in IDLE.
REQ-006 Port stop  input  1  abort the scan in progress.
REQ-007 Port mode_cont  input  1  1 = wrap and repeat passes until stop; 0 = single pass; latched at start.
REQ-008 Port ch_mask  input  8  channel enable mask; bit i = channel i (0 = bus a ... 7 = bus h); latched at start.
REQ-009 Port dwell  input  DWELL_W  cycles per channel minus one; latched at start.
REQ-010 Ports sel0, sel1, sel2  output  1 each  channel select for the downstream 4-bit 8:1 mux; sel2 MSB, sel0 LSB.
REQ-011 Port enable  output  1  downstream mux enable.
REQ-012 Port ch_valid  output  1  one-cycle sample strobe on the last dwell cycle of each channel.
REQ-013 Port busy  output  1  high while in SCAN.
REQ-014 Port done  output  1  one-cycle pulse on normal pass completion.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-017 IDLE: start=1, stop=0 and ch_mask != 0 at edge N -> SCAN at edge N, with mask, dwell and mode latched.
REQ-018 At edge N the outputs SHALL become sel = lowest set mask bit, enable=1, busy=1.
REQ-019 IDLE, start=1 with ch_mask=0 -> stay in IDLE with no output change and no done.
REQ-020 IDLE, start=1 and stop=1 in the same cycle -> stop wins; stay in IDLE.
REQ-021 SCAN: each selected channel SHALL be held for dwell+1 cycles (dwell=0 -> 1 cycle); a DWELL_W-bit counter clears on every channel change.
REQ-022 ch_valid=1 exactly in the final dwell cycle of each channel, with sel still showing that channel.
REQ-023 After the final dwell cycle, sel SHALL advance to the next higher set bit in the latched mask; unmasked channels are skipped with no idle cycles.
REQ-024 Wrap point, mode_cont=0 -> DONE (enable=0, busy=0, done=1 for one cycle, sel holds last channel) -> IDLE on the next edge (done=0, sel=000).
REQ-025 Wrap point, mode_cont=1 -> sel wraps to the lowest set bit; stay in SCAN; no done.
REQ-026 Single-bit mask: the same channel repeats; ch_valid pulses every dwell+1 cycles.
REQ-027 stop=1 in SCAN (any cycle, including a ch_valid cycle) -> IDLE at the next edge.
REQ-028 On stop, outputs SHALL be enable=0, busy=0, ch_valid=0, sel=000, with no done pulse.
REQ-029 start SHALL be ignored in SCAN and DONE; changes to ch_mask, dwell and mode_cont SHALL be ignored outside IDLE.
REQ-030 In IDLE the outputs SHALL be sel=000, enable=0, ch_valid=0, busy=0, done=0.

Reset
REQ-031 rst_n=0 SHALL immediately, with no clock, force state IDLE and clear all outputs, the dwell counter and the latched mask, dwell and mode.
REQ-032 Reset asserted mid-SCAN SHALL abort with no done pulse.
REQ-033 After rst_n rises, the first start is honoured on the first rising edge.

Verification
REQ-034 Scenario: mask=8'hFF, dwell=0, mode_cont=0, start pulse -> sel 0..7 one cycle each, ch_valid high 8 cycles, done one cycle after channel 7, busy high 8 cycles.
REQ-035 Scenario: mask=8'b1010_0100, dwell=2 -> channel 2 then 5 then 7, 3 cycles each, ch_valid on the 3rd cycle of each, done once.
REQ-036 Scenario: mask=8'h81, dwell=1, mode_cont=1, stop after 10 cycles -> sequence 0,0,7,7,0,0,7,7,0,0, then IDLE outputs, no done.
REQ-037 Scenario: start with mask=0, then start and stop together with mask=8'hFF -> both cases stay IDLE with all outputs 0.
REQ-038 Scenario: change mask and dwell mid-scan, and pulse start in SCAN -> sequence unaffected.
REQ-039 Scenario: rst_n low between edges mid-scan -> outputs cleared before the next edge; new start after release -> sel = lowest set bit.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Channel scan controller for a downstream 4-bit 8:1 mux.
//                Walks the set bits of a latched channel mask. Each channel is
//                held for (dwell+1) cycles, with a sample strobe on its last
//                cycle. Runs a single pass or repeats continuously.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel0,
  output logic               sel1,
  output logic               sel2,
  output logic               enable,
  output logic               ch_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic                 enable_q, enable_d;
  logic                 ch_valid_q, ch_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [7:0]           w_above;
  logic                 w_has_next;
  logic [2:0]           w_next;
  logic [2:0]           w_first;
  logic [DWELL_W-1:0]   w_cnt_inc;

  // Index of the lowest set bit; caller guarantees the mask is non-zero
  // whenever the result is used.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Channels strictly above the current one, so skipping unmasked channels
  // costs no extra cycles.
  assign w_above    = mask_q & (8'hFE << sel_q);
  assign w_has_next = |w_above;
  assign w_next     = lowest_set(w_above);
  assign w_first    = lowest_set(mask_q);
  assign w_cnt_inc  = cnt_q + 1'b1;

  // State, latched configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      sel_q      <= 3'd0;
      enable_q   <= 1'b0;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      enable_q   <= enable_d;
      ch_valid_q <= ch_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead so
  // that every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    enable_d   = enable_q;
    ch_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop && (ch_mask != 8'h00)) begin
          state_d    = S_SCAN;
          mask_d     = ch_mask;
          dwell_d    = dwell;
          mode_d     = mode_cont;
          cnt_d      = '0;
          sel_d      = lowest_set(ch_mask);
          enable_d   = 1'b1;
          busy_d     = 1'b1;
          ch_valid_d = (dwell == '0);
        end
      end

      S_SCAN: begin
        if (stop) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          sel_d    = 3'd0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q == dwell_q) begin
          // Last dwell cycle of this channel: move on.
          cnt_d = '0;
          if (w_has_next) begin
            sel_d      = w_next;
            ch_valid_d = (dwell_q == '0);
          end else if (mode_q) begin
            sel_d      = w_first;
            ch_valid_d = (dwell_q == '0);
          end else begin
            // End of a single pass; sel holds the last channel for one cycle.
            state_d  = S_DONE;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          cnt_d      = w_cnt_inc;
          ch_valid_d = (w_cnt_inc == dwell_q);
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        sel_d    = 3'd0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        sel_d    = 3'd0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign sel0     = sel_q[0];
  assign sel1     = sel_q[1];
  assign sel2     = sel_q[2];
  assign enable   = enable_q;
  assign ch_valid = ch_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_ctrl
//  Description : Self-checking bench for mux_scan_ctrl. A queue of expected
//                per-cycle outputs is built from the mask/dwell/mode whenever
//                a scan is accepted and compared against the DUT each cycle;
//                directed scenarios add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               mode_cont;
  logic [7:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic               sel0, sel1, sel2;
  logic               enable, ch_valid, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2),
    .enable    (enable),
    .ch_valid  (ch_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       val;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       mq[$];
  logic [7:0] m_mask;
  int         m_dwell;
  logic       m_cont;

  // One pass = every enabled channel in ascending order for dwell+1 cycles,
  // strobe on the last; single pass ends with a one-cycle done entry.
  task automatic add_pass();
    logic [2:0] last;
    last = 3'd0;
    for (int ch = 0; ch < 8; ch++) begin
      if (m_mask[ch]) begin
        for (int k = 0; k <= m_dwell; k++)
          mq.push_back('{sel: 3'(ch), en: 1'b1, val: (k == m_dwell), busy: 1'b1, done: 1'b0});
        last = 3'(ch);
      end
    end
    if (!m_cont)
      mq.push_back('{sel: last, en: 1'b0, val: 1'b0, busy: 1'b0, done: 1'b1});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() > 0) begin
      if (mq[0].busy && stop) begin
        mq.delete();
      end else begin
        void'(mq.pop_front());
        if (m_cont && mq.size() < 40) add_pass();
      end
    end else if (start && !stop && ch_mask != 8'h00) begin
      m_mask  = ch_mask;
      m_dwell = int'(dwell);
      m_cont  = mode_cont;
      add_pass();
      if (m_cont) add_pass();
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    exp_t e;
    e = (mq.size() > 0) ? mq[0] : exp_t'(0);
    chk("cycle_outputs {sel,en,valid,busy,done}",
        32'({sel2, sel1, sel0, enable, ch_valid, busy, done}), 32'(e));
  end

  // ---------------- directed stimulus ----------------
  int tr_sel [32];
  int tr_val [32];
  int tr_busy[32];
  int tr_en  [32];
  int tr_done[32];

  task automatic launch(input logic [7:0] m, input int dw, input logic cont);
    @(negedge clk);
    ch_mask   = m;
    dwell     = DWELL_W'(dw);
    mode_cont = cont;
    start     = 1'b1;
  endtask

  task automatic capture(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      @(negedge clk);
      start      = 1'b0;
      tr_sel[c]  = int'({sel2, sel1, sel0});
      tr_val[c]  = int'(ch_valid);
      tr_busy[c] = int'(busy);
      tr_en[c]   = int'(enable);
      tr_done[c] = int'(done);
    end
  endtask

  function automatic int count(input int a[32], input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += a[i];
    return s;
  endfunction

  initial begin
    int exp36[10];
    int exp38[9];
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    ch_mask = 8'h00; dwell = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_no_clock", 32'({sel2, sel1, sel0, enable, ch_valid, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full mask, dwell 0, single pass
    launch(8'hFF, 0, 1'b0);
    capture(0, 10);
    chk("ff_valid_count", 32'(count(tr_val, 10)), 32'd8);
    chk("ff_busy_count",  32'(count(tr_busy, 10)), 32'd8);
    chk("ff_done_count",  32'(count(tr_done, 10)), 32'd1);
    chk("ff_sel_c0",      32'(tr_sel[0]), 32'd0);
    chk("ff_sel_c5",      32'(tr_sel[5]), 32'd5);
    chk("ff_done_c8",     32'(tr_done[8]), 32'd1);
    chk("ff_sel_hold_c8", 32'(tr_sel[8]), 32'd7);
    chk("ff_idle_sel_c9", 32'(tr_sel[9]), 32'd0);

    // Sparse mask 1010_0100, dwell 2
    launch(8'b1010_0100, 2, 1'b0);
    capture(0, 11);
    chk("sp_sel_c0", 32'(tr_sel[0]), 32'd2);
    chk("sp_sel_c3", 32'(tr_sel[3]), 32'd5);
    chk("sp_sel_c6", 32'(tr_sel[6]), 32'd7);
    chk("sp_valid_c2_c5_c8", 32'({tr_val[2][0], tr_val[5][0], tr_val[8][0]}), 32'b111);
    chk("sp_valid_count", 32'(count(tr_val, 11)), 32'd3);
    chk("sp_done_c9",     32'(tr_done[9]), 32'd1);
    chk("sp_done_count",  32'(count(tr_done, 11)), 32'd1);

    // Continuous, mask 0x81, dwell 1, stop after 10 cycles (on a strobe cycle)
    exp36 = '{0, 0, 7, 7, 0, 0, 7, 7, 0, 0};
    launch(8'h81, 1, 1'b1);
    capture(0, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("cont_sel_c%0d", i), 32'(tr_sel[i]), 32'(exp36[i]));
    chk("cont_valid_c9", 32'(tr_val[9]), 32'd1);
    stop = 1'b1;
    capture(10, 2);
    stop = 1'b0;
    chk("cont_stop_idle", 32'(tr_busy[10] + tr_en[10] + tr_val[10] + tr_sel[10]), 32'd0);
    chk("cont_no_done", 32'(count(tr_done, 12)), 32'd0);

    // start with empty mask, then start+stop together
    launch(8'h00, 0, 1'b0);
    capture(0, 3);
    ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
    capture(3, 3);
    stop = 1'b0;
    chk("noscan_busy", 32'(count(tr_busy, 6)), 32'd0);
    chk("noscan_en",   32'(count(tr_en, 6)), 32'd0);
    chk("noscan_done", 32'(count(tr_done, 6)), 32'd0);

    // Config changes and start pulse mid-scan are ignored
    exp38 = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
    launch(8'h0F, 1, 1'b0);
    capture(0, 3);
    ch_mask = 8'hFF; dwell = '0; mode_cont = 1'b1; start = 1'b1;
    capture(3, 8);
    for (int i = 0; i < 9; i++)
      chk($sformatf("ign_sel_c%0d", i), 32'(tr_sel[i]), 32'(exp38[i]));
    chk("ign_done_c8", 32'(tr_done[8]), 32'd1);
    chk("ign_idle_c10", 32'(tr_busy[10] + tr_en[10]), 32'd0);
    mode_cont = 1'b0;

    // Asynchronous reset mid-scan, then immediate restart
    launch(8'h3C, 3, 1'b0);
    capture(0, 3);
    chk("rst_pre_sel", 32'(tr_sel[2]), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_scan", 32'({sel2, sel1, sel0, enable, ch_valid, busy, done}), 32'd0);
    ch_mask = 8'h30; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 12);
    chk("rst_restart_sel", 32'(tr_sel[0]), 32'd4);
    chk("rst_restart_busy", 32'(tr_busy[0]), 32'd1);
    chk("rst_sel_c4", 32'(tr_sel[4]), 32'd5);
    chk("rst_done_c8", 32'(tr_done[8]), 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
